axi4_a23_req_arb: RTL and testbench

- Request scheduler in front of the Amber23 AXI4 bus-interface unit.
- Arbitrates between the core data port (single reads/writes, swap pairs) and the cache line-fill port, then presents one registered request at a time on the bus-interface select/cache_req channel.
- Guarantees swap atomicity with a lock.
- Bounds core starvation under continuous line fills.

---
 rtl/axi4_a23_req_arb.sv | 218 +++++++++++++++++++++
 tb/tb_axi4_a23_req_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_a23_req_arb.sv
// axi4_a23_req_arb: request scheduler in front of the Amber23 AXI4 bus-interface unit.
// It arbitrates between the core data port and the cache line-fill port, and
// presents one registered request at a time on the select/cache_req channel.
// A lock keeps the read and write halves of a swap together. A starvation counter
// lets the core win after STARVE_LIMIT cache fills have completed while it waited.
// Optional build macro: A23_ARB_STATS_EN adds the grant and lock-cycle counters.
module axi4_a23_req_arb #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_core_sel,
  input  logic        i_core_we,
  input  logic [3:0]  i_core_be,
  input  logic [31:0] i_core_wdata,
  input  logic [31:0] i_core_addr,
  input  logic        i_core_excl,
  output logic        o_core_stall,
  input  logic        i_ca_req,
  input  logic [31:0] i_ca_addr,
  output logic        o_ca_stall,
  output logic        o_select,
  output logic        o_cache_req,
  output logic        o_write_enable,
  output logic [3:0]  o_byte_enable,
  output logic [31:0] o_write_data,
  output logic [31:0] o_address,
  output logic        o_exclusive,
`ifdef A23_ARB_STATS_EN
  output logic [31:0] o_core_grants,
  output logic [31:0] o_ca_grants,
  output logic [31:0] o_lock_cycles,
`endif
  input  logic        i_stall,
  input  logic        i_stall_cache
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CACHE = 2'd1,
    ST_CORE  = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  state_t            state_r, state_nxt_s;
  logic              lock_r, lock_nxt_s;
  logic [CNT_W-1:0]  starve_cnt_r, starve_cnt_nxt_s;
  logic              select_r, cache_req_r, we_r, excl_r;
  logic [3:0]        be_r;
  logic [31:0]       wdata_r, addr_r;
  logic              select_nxt_s, cache_req_nxt_s, we_nxt_s, excl_nxt_s;
  logic [3:0]        be_nxt_s;
  logic [31:0]       wdata_nxt_s, addr_nxt_s;
  logic              grant_cache_s, grant_core_s, core_done_s, cache_done_s;

  // Grant decisions and completion detection for the current cycle
  always_comb begin
    core_done_s   = (state_r == ST_CORE)  && !i_stall;
    cache_done_s  = (state_r == ST_CACHE) && !i_stall_cache;
    grant_cache_s = (state_r == ST_IDLE) && !lock_r && i_ca_req &&
                    (!i_core_sel || (starve_cnt_r < LIMIT_C));
    grant_core_s  = i_core_sel &&
                    (((state_r == ST_IDLE) && !grant_cache_s) || (state_r == ST_LOCK));
  end

  // State register: a low reset drops any grant in progress
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_cache_s)     state_nxt_s = ST_CACHE;
        else if (grant_core_s) state_nxt_s = ST_CORE;
        else                   state_nxt_s = ST_IDLE;
      end
      ST_CACHE: begin
        if (cache_done_s) state_nxt_s = ST_IDLE;
        else              state_nxt_s = ST_CACHE;
      end
      ST_CORE: begin
        if (core_done_s && excl_r && !we_r) state_nxt_s = ST_LOCK;
        else if (core_done_s)               state_nxt_s = ST_IDLE;
        else                                state_nxt_s = ST_CORE;
      end
      ST_LOCK: begin
        if (grant_core_s) state_nxt_s = ST_CORE;
        else              state_nxt_s = ST_LOCK;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output, lock and starvation-counter next values
  always_comb begin
    select_nxt_s     = select_r;
    cache_req_nxt_s  = cache_req_r;
    we_nxt_s         = we_r;
    be_nxt_s         = be_r;
    wdata_nxt_s      = wdata_r;
    addr_nxt_s       = addr_r;
    excl_nxt_s       = excl_r;
    lock_nxt_s       = lock_r;
    starve_cnt_nxt_s = starve_cnt_r;
    if (grant_cache_s) begin
      cache_req_nxt_s = 1'b1;
      select_nxt_s    = 1'b0;
      we_nxt_s        = 1'b0;
      be_nxt_s        = 4'hf;
      wdata_nxt_s     = 32'h0;
      addr_nxt_s      = i_ca_addr;
      excl_nxt_s      = 1'b0;
    end else if (grant_core_s) begin
      select_nxt_s    = 1'b1;
      cache_req_nxt_s = 1'b0;
      we_nxt_s        = i_core_we;
      be_nxt_s        = i_core_be;
      wdata_nxt_s     = i_core_wdata;
      addr_nxt_s      = i_core_addr;
      excl_nxt_s      = i_core_excl;
    end else if (core_done_s || cache_done_s) begin
      // Return the bus fields to zero between grants
      select_nxt_s    = 1'b0;
      cache_req_nxt_s = 1'b0;
      we_nxt_s        = 1'b0;
      be_nxt_s        = 4'h0;
      wdata_nxt_s     = 32'h0;
      addr_nxt_s      = 32'h0;
      excl_nxt_s      = 1'b0;
    end else begin
      select_nxt_s    = select_r;
    end

    if (core_done_s) begin
      lock_nxt_s       = excl_r && !we_r;
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cache_done_s && i_core_sel) begin
      lock_nxt_s       = lock_r;
      starve_cnt_nxt_s = (starve_cnt_r < LIMIT_C) ? starve_cnt_r + 1'b1 : LIMIT_C;
    end else if ((state_r == ST_IDLE) && !i_core_sel) begin
      lock_nxt_s       = lock_r;
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      lock_nxt_s       = lock_r;
    end
  end

  // Datapath, lock and starvation registers
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      select_r     <= 1'b0;
      cache_req_r  <= 1'b0;
      we_r         <= 1'b0;
      be_r         <= 4'h0;
      wdata_r      <= 32'h0;
      addr_r       <= 32'h0;
      excl_r       <= 1'b0;
      lock_r       <= 1'b0;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      select_r     <= select_nxt_s;
      cache_req_r  <= cache_req_nxt_s;
      we_r         <= we_nxt_s;
      be_r         <= be_nxt_s;
      wdata_r      <= wdata_nxt_s;
      addr_r       <= addr_nxt_s;
      excl_r       <= excl_nxt_s;
      lock_r       <= lock_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Requester stalls: released only in the completing cycle, held low during reset
  always_comb begin
    o_core_stall = i_rstn && i_core_sel && !core_done_s;
    o_ca_stall   = i_rstn && i_ca_req && !cache_done_s;
  end

  assign o_select       = select_r;
  assign o_cache_req    = cache_req_r;
  assign o_write_enable = we_r;
  assign o_byte_enable  = be_r;
  assign o_write_data   = wdata_r;
  assign o_address      = addr_r;
  assign o_exclusive    = excl_r;

`ifdef A23_ARB_STATS_EN
  logic [31:0] core_grants_r, ca_grants_r, lock_cycles_r;

  // Completion and lock-cycle counters, wrapping modulo 2^32
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      core_grants_r <= 32'h0;
      ca_grants_r   <= 32'h0;
      lock_cycles_r <= 32'h0;
    end else begin
      core_grants_r <= core_grants_r + {31'h0, core_done_s};
      ca_grants_r   <= ca_grants_r + {31'h0, cache_done_s};
      lock_cycles_r <= lock_cycles_r + {31'h0, (state_r == ST_LOCK)};
    end
  end

  assign o_core_grants = core_grants_r;
  assign o_ca_grants   = ca_grants_r;
  assign o_lock_cycles = lock_cycles_r;
`endif

endmodule

// File: tb/tb_axi4_a23_req_arb.sv
// Self-checking bench for axi4_a23_req_arb: per-cycle vector table plus
// hand-written sequences for starvation, swap lock and mid-grant reset.
module tb_axi4_a23_req_arb;

  logic        i_clk = 1'b0;
  logic        i_rstn, i_core_sel, i_core_we, i_core_excl, i_ca_req, i_stall, i_stall_cache;
  logic [3:0]  i_core_be;
  logic [31:0] i_core_wdata, i_core_addr, i_ca_addr;
  logic        o_core_stall, o_ca_stall, o_select, o_cache_req, o_write_enable, o_exclusive;
  logic [3:0]  o_byte_enable;
  logic [31:0] o_write_data, o_address;
`ifdef A23_ARB_STATS_EN
  logic [31:0] o_core_grants, o_ca_grants, o_lock_cycles;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  axi4_a23_req_arb #(.STARVE_LIMIT(3), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_core_sel(i_core_sel), .i_core_we(i_core_we), .i_core_be(i_core_be),
    .i_core_wdata(i_core_wdata), .i_core_addr(i_core_addr), .i_core_excl(i_core_excl),
    .o_core_stall(o_core_stall), .i_ca_req(i_ca_req), .i_ca_addr(i_ca_addr),
    .o_ca_stall(o_ca_stall), .o_select(o_select), .o_cache_req(o_cache_req),
    .o_write_enable(o_write_enable), .o_byte_enable(o_byte_enable),
    .o_write_data(o_write_data), .o_address(o_address), .o_exclusive(o_exclusive),
`ifdef A23_ARB_STATS_EN
    .o_core_grants(o_core_grants), .o_ca_grants(o_ca_grants), .o_lock_cycles(o_lock_cycles),
`endif
    .i_stall(i_stall), .i_stall_cache(i_stall_cache)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // The two bus strobes must never be high together
  always @(negedge i_clk) begin
    if (i_rstn === 1'b1) begin
      n_checks++;
      if (o_select && o_cache_req) begin
        n_fails++;
        $display("FAIL strobe_excl: got select=%0b cache_req=%0b expected not both", o_select, o_cache_req);
      end
    end
  end

  typedef struct {
    logic        sel, we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic        ca;
    logic [31:0] ca_addr;
    logic        st, stc;
    logic        e_sel, e_ca, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic        e_cst, e_cast;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sel, we, input logic [3:0] be, input logic [31:0] addr,
                     input logic ca, input logic [31:0] ca_addr, input logic st, stc,
                     input logic e_sel, e_ca, e_we, input logic [3:0] e_be,
                     input logic [31:0] e_addr, input logic e_cst, e_cast);
    vec_t v;
    v.sel = sel; v.we = we; v.be = be; v.addr = addr; v.ca = ca; v.ca_addr = ca_addr;
    v.st = st; v.stc = stc; v.e_sel = e_sel; v.e_ca = e_ca; v.e_we = e_we; v.e_be = e_be;
    v.e_addr = e_addr; v.e_cst = e_cst; v.e_cast = e_cast;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    i_core_sel = 1'b0; i_core_we = 1'b0; i_core_be = 4'h0; i_core_wdata = 32'h0;
    i_core_addr = 32'h0; i_core_excl = 1'b0; i_ca_req = 1'b0; i_ca_addr = 32'h0;
    i_stall = 1'b0; i_stall_cache = 1'b0;
  endtask

  int  ncomp;
  bit  got;

  initial begin
    // Test 1: lone core read with three stall cycles
    add(1'b1, 1'b0, 4'hf, 32'h1000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    1'b1, 1'b0);
    add(1'b1, 1'b0, 4'hf, 32'h1000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hf, 32'h1000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 4'hf, 32'h1000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hf, 32'h1000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 4'hf, 32'h1000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hf, 32'h1000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 4'hf, 32'h1000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hf, 32'h1000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'h0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    1'b0, 1'b0);
    // Test 2: simultaneous requests, cache first, one bubble, then core write
    add(1'b1, 1'b1, 4'h3, 32'h1100, 1'b1, 32'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    1'b1, 1'b1);
    add(1'b1, 1'b1, 4'h3, 32'h1100, 1'b1, 32'h4000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hf, 32'h4000, 1'b1, 1'b0);
    add(1'b1, 1'b1, 4'h3, 32'h1100, 1'b0, 32'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    1'b1, 1'b0);
    add(1'b1, 1'b1, 4'h3, 32'h1100, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 32'h1100, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'h0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    1'b0, 1'b0);
    // Test 5: address changes while stalled, latched value must hold
    add(1'b1, 1'b0, 4'hf, 32'h1000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    1'b1, 1'b0);
    add(1'b1, 1'b0, 4'hf, 32'h3000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hf, 32'h1000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 4'hf, 32'h3000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hf, 32'h1000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 4'hf, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hf, 32'h1000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'h0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    1'b0, 1'b0);

    // Reset and reset-state checks
    idle_inputs();
    i_rstn = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_select", {31'h0, o_select}, 32'h0);
    chk("rst_cache_req", {31'h0, o_cache_req}, 32'h0);
    chk("rst_addr", o_address, 32'h0);
    chk("rst_be", {28'h0, o_byte_enable}, 32'h0);
    i_rstn = 1'b1;

    // Apply the vector table, one vector per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge i_clk);
      i_core_sel = vecs[i].sel; i_core_we = vecs[i].we; i_core_be = vecs[i].be;
      i_core_addr = vecs[i].addr; i_ca_req = vecs[i].ca; i_ca_addr = vecs[i].ca_addr;
      i_stall = vecs[i].st; i_stall_cache = vecs[i].stc;
      #1;
      chk($sformatf("v%0d_select", i),     {31'h0, o_select},       {31'h0, vecs[i].e_sel});
      chk($sformatf("v%0d_cache_req", i),  {31'h0, o_cache_req},    {31'h0, vecs[i].e_ca});
      chk($sformatf("v%0d_we", i),         {31'h0, o_write_enable}, {31'h0, vecs[i].e_we});
      chk($sformatf("v%0d_be", i),         {28'h0, o_byte_enable},  {28'h0, vecs[i].e_be});
      chk($sformatf("v%0d_addr", i),       o_address,               vecs[i].e_addr);
      chk($sformatf("v%0d_core_stall", i), {31'h0, o_core_stall},   {31'h0, vecs[i].e_cst});
      chk($sformatf("v%0d_ca_stall", i),   {31'h0, o_ca_stall},     {31'h0, vecs[i].e_cast});
    end

    // Test 3: continuous cache fills, core write forced through after 3 completions
    @(negedge i_clk);
    i_core_sel = 1'b1; i_core_we = 1'b1; i_core_be = 4'h5; i_core_addr = 32'h5000;
    i_core_wdata = 32'h12345678; i_ca_req = 1'b1; i_ca_addr = 32'h8000;
    i_stall = 1'b0; i_stall_cache = 1'b0;
    for (int r = 0; r < 2; r++) begin
      ncomp = 0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        #1;
        if (o_cache_req && !i_stall_cache) ncomp++;
        if (o_select) begin
          got = 1'b1;
          chk($sformatf("starve%0d_we", r),    {31'h0, o_write_enable}, 32'h1);
          chk($sformatf("starve%0d_be", r),    {28'h0, o_byte_enable},  32'h5);
          chk($sformatf("starve%0d_addr", r),  o_address,               32'h5000);
          chk($sformatf("starve%0d_wdata", r), o_write_data,            32'h12345678);
        end
        @(negedge i_clk);
      end
      chk($sformatf("starve%0d_got_core", r), {31'h0, got}, 32'h1);
      chk($sformatf("starve%0d_fills", r), ncomp, 32'd3);
    end
    idle_inputs();
    repeat (2) @(negedge i_clk);

    // Test 4: swap with a cache request raised during the read half
    i_core_sel = 1'b1; i_core_excl = 1'b1; i_core_we = 1'b0; i_core_be = 4'hf; i_core_addr = 32'h2000;
    #1; chk("swap_c0_select", {31'h0, o_select}, 32'h0);
    @(negedge i_clk);
    i_ca_req = 1'b1; i_ca_addr = 32'h6000;
    #1; chk("swap_rd_select", {31'h0, o_select}, 32'h1);
    chk("swap_rd_excl", {31'h0, o_exclusive}, 32'h1);
    chk("swap_rd_addr", o_address, 32'h2000);
    chk("swap_rd_ca_stall", {31'h0, o_ca_stall}, 32'h1);
    @(negedge i_clk);
    i_core_sel = 1'b0; i_core_excl = 1'b0;
    #1; chk("swap_lock1_cache_req", {31'h0, o_cache_req}, 32'h0);
    chk("swap_lock1_select", {31'h0, o_select}, 32'h0);
    @(negedge i_clk);
    #1; chk("swap_lock2_cache_req", {31'h0, o_cache_req}, 32'h0);
    @(negedge i_clk);
    i_core_sel = 1'b1; i_core_we = 1'b1; i_core_wdata = 32'hdeadbeef;
    #1; chk("swap_lock3_cache_req", {31'h0, o_cache_req}, 32'h0);
    chk("swap_lock3_core_stall", {31'h0, o_core_stall}, 32'h1);
    @(negedge i_clk);
    #1; chk("swap_wr_select", {31'h0, o_select}, 32'h1);
    chk("swap_wr_we", {31'h0, o_write_enable}, 32'h1);
    chk("swap_wr_wdata", o_write_data, 32'hdeadbeef);
    chk("swap_wr_cache_req", {31'h0, o_cache_req}, 32'h0);
    @(negedge i_clk);
    i_core_sel = 1'b0; i_core_we = 1'b0;
    #1; chk("swap_bubble_cache_req", {31'h0, o_cache_req}, 32'h0);
    @(negedge i_clk);
    #1; chk("swap_fill_cache_req", {31'h0, o_cache_req}, 32'h1);
    chk("swap_fill_addr", o_address, 32'h6000);
    @(negedge i_clk);
    i_ca_req = 1'b0;
    #1; chk("swap_done_cache_req", {31'h0, o_cache_req}, 32'h0);

    // Test 6: reset while a cache fill is stalled
    @(negedge i_clk);
`ifdef A23_ARB_STATS_EN
    chk("stats_lock_cycles", o_lock_cycles, 32'd3);
`endif
    i_ca_req = 1'b1; i_ca_addr = 32'h7000; i_stall_cache = 1'b1;
    @(negedge i_clk);
    #1; chk("rst6_cache_req", {31'h0, o_cache_req}, 32'h1);
    chk("rst6_ca_stall", {31'h0, o_ca_stall}, 32'h1);
    i_rstn = 1'b0;
    #1; chk("rst6_ca_stall_in_rst", {31'h0, o_ca_stall}, 32'h0);
    @(negedge i_clk);
    i_rstn = 1'b1; i_ca_req = 1'b0; i_stall_cache = 1'b0;
    #1; chk("rst6_cache_req_clr", {31'h0, o_cache_req}, 32'h0);
    chk("rst6_addr_clr", o_address, 32'h0);
    chk("rst6_be_clr", {28'h0, o_byte_enable}, 32'h0);
    chk("rst6_lock_clr", {31'h0, dut.lock_r}, 32'h0);
`ifdef A23_ARB_STATS_EN
    chk("rst6_core_grants", o_core_grants, 32'h0);
    chk("rst6_ca_grants", o_ca_grants, 32'h0);
    chk("rst6_lock_cycles", o_lock_cycles, 32'h0);
`endif
    @(negedge i_clk);
    #1; chk("rst6_idle_cache_req", {31'h0, o_cache_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
